// File: rtl/alu_pipe.sv
// Two-stage pipelined {M,S1,S0} ALU with valid/ready handshakes.
// Define ALU_ACC_EN to build the accumulator feedback path selected by acc_sel.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_cin;
    logic             s1_adv;
    logic             accept;
    logic             xfer;

    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] addend;
    logic             carry;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_f;
    logic             res_cout;
    logic             res_ovf;
    logic             res_zero;

    assign s1_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;
    assign xfer     = s1_valid && s1_adv;

`ifdef ALU_ACC_EN
    logic             s1_acc_sel;
    logic [WIDTH-1:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_acc_sel <= 1'b0;
        end else if (accept) begin
            s1_acc_sel <= acc_sel;
        end
    end

    // acc is written on the same edge that moves the previous beat out of S1,
    // so a chained beat sitting in S1 always sees its predecessor's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (xfer) begin
            acc <= res_f;
        end
    end

    assign opnd_a = s1_acc_sel ? acc : s1_a;
`else
    logic unused_acc_sel;

    assign unused_acc_sel = acc_sel;
    assign opnd_a         = s1_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
            s1_cin   <= cin;
        end else if (xfer) begin
            s1_valid <= 1'b0;
        end
    end

    // Every arithmetic op is one adder with a selected addend and carry-in.
    always_comb begin
        addend   = s1_b;
        carry    = s1_cin;
        res_f    = '0;
        res_cout = 1'b0;
        res_ovf  = 1'b0;
        case (s1_op[1:0])
            2'b00: begin addend = s1_b;   carry = s1_cin; end
            2'b01: begin addend = ~s1_b;  carry = 1'b1;   end
            2'b10: begin addend = '0;     carry = 1'b1;   end
            2'b11: begin addend = '1;     carry = 1'b0;   end
        endcase
        sum = {1'b0, opnd_a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};
        if (!s1_op[2]) begin
            res_f    = sum[WIDTH-1:0];
            res_cout = sum[WIDTH];
            res_ovf  = (opnd_a[WIDTH-1] == addend[WIDTH-1]) &&
                       (sum[WIDTH-1] != opnd_a[WIDTH-1]);
        end else begin
            case (s1_op[1:0])
                2'b00: res_f = opnd_a & s1_b;
                2'b01: res_f = opnd_a | s1_b;
                2'b10: res_f = opnd_a ^ s1_b;
                2'b11: res_f = ~opnd_a;
            endcase
        end
        res_zero = (res_f == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            f         <= res_f;
            cout      <= res_cout;
            ovf       <= res_ovf;
            zero      <= res_zero;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8: vector table, corner sequences
// and a randomized stream scored against an arithmetic reference model.
module tb_alu_pipe;

    localparam int WIDTH = 8;
`ifdef ALU_ACC_EN
    localparam bit useAcc = 1'b1;
`else
    localparam bit useAcc = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             cin;
    logic             acc_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             ovf;
    logic             zero;

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCount  = 0;
    int acceptCount = 0;

    // Expected and observed results packed as {cout, ovf, zero, f}
    logic [10:0] expQ[$];
    logic [10:0] obsLog[$];
    int          obsCyc[$];
    logic [7:0]  modelAcc = '0;
    logic        holdValid = 1'b0;
    logic [10:0] holdVal;
    logic [7:0]  aEff;
    logic [10:0] res;
    logic        randRun;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expF;
        logic       expCout;
        logic       expOvf;
        logic       expZero;
    } vecT;

    vecT vecs[16];

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .acc_sel   (acc_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference ALU from integer arithmetic: unsigned sum for carry, signed sum range for overflow.
    function automatic logic [10:0] refAlu(input logic [2:0] o, input logic [7:0] x,
                                           input logic [7:0] y, input logic c);
        int addVal;
        int carryIn;
        int uSum;
        int sA;
        int sAdd;
        int sSum;
        logic [7:0] r;
        logic co;
        logic ov;
        addVal  = 0;
        carryIn = 0;
        co      = 1'b0;
        ov      = 1'b0;
        r       = '0;
        if (o[2] == 1'b0) begin
            case (o[1:0])
                2'd0: begin addVal = int'(y);       carryIn = int'(c); end
                2'd1: begin addVal = 255 - int'(y); carryIn = 1;       end
                2'd2: begin addVal = 0;             carryIn = 1;       end
                default: begin addVal = 255;        carryIn = 0;       end
            endcase
            uSum = int'(x) + addVal + carryIn;
            r    = 8'(uSum % 256);
            co   = (uSum >= 256);
            sA   = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
            sAdd = (addVal >= 128) ? addVal - 256 : addVal;
            sSum = sA + sAdd + carryIn;
            ov   = (sSum > 127) || (sSum < -128);
        end else begin
            case (o[1:0])
                2'd0: r = x & y;
                2'd1: r = x | y;
                2'd2: r = x ^ y;
                default: r = ~x;
            endcase
        end
        return {co, ov, (r == 8'h00), r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    // Offer one beat starting at posedge+1; returns at posedge+1 after it is accepted.
    task automatic applyStimulus(input logic [2:0] opV, input logic [7:0] aV,
                                 input logic [7:0] bV, input logic cinV, input logic accV);
        int waitCycles;
        waitCycles = 0;
        op       = opV;
        a        = aV;
        b        = bV;
        cin      = cinV;
        acc_sel  = accV;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waitCycles++;
            if (waitCycles > 200) begin
                reportTimeout("accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) reportTimeout("drain");
        @(posedge clk);
        #1;
    endtask

    // Monitor/scoreboard: decisions for the next posedge are sampled at each negedge.
    initial begin
        forever begin
            @(negedge clk);
            cycleCount++;
            if (!rst_n) begin
                expQ.delete();
                modelAcc  = '0;
                holdValid = 1'b0;
            end else begin
                if (holdValid)
                    checkOutput("stall_hold", {out_valid, cout, ovf, zero, f}, {1'b1, holdVal});
                holdValid = out_valid && !out_ready;
                holdVal   = {cout, ovf, zero, f};
                if (out_valid && out_ready) begin
                    obsLog.push_back({cout, ovf, zero, f});
                    obsCyc.push_back(cycleCount);
                    if (expQ.size() == 0) begin
                        testsRun++;
                        testsFailed++;
                        $display("[TB] FAIL extra_beat: got f=%0h, expected no beat", f);
                    end else begin
                        checkOutput("scoreboard", {cout, ovf, zero, f}, expQ.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    aEff     = (useAcc && acc_sel) ? modelAcc : a;
                    res      = refAlu(op, aEff, b, cin);
                    modelAcc = res[7:0];
                    expQ.push_back(res);
                    acceptCount++;
                end
            end
        end
    end

    initial begin
        logic [7:0] chainExp[4];
        int acceptBase;

        vecs[0]  = '{3'b000, 8'h55, 8'h44, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h55, 8'h44, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 8'h55, 8'h44, 1'b0, 8'h56, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 8'h55, 8'h44, 1'b0, 8'h54, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 8'h55, 8'h44, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'b101, 8'h55, 8'h44, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 8'h55, 8'h44, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b111, 8'h55, 8'h44, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b010, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b001, 8'h3C, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b000, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b011, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{3'b010, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        cin       = 1'b0;
        acc_sel   = 1'b0;
        randRun   = 1'b0;

        // Reset state: {out_valid, in_ready, cout, ovf, zero, f}
        repeat (2) @(negedge clk);
        checkOutput("reset_state", {out_valid, in_ready, cout, ovf, zero, f}, {2'b01, 11'h000});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            obsLog.delete();
            obsCyc.delete();
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            waitDrain();
            checkOutput($sformatf("vec%0d_count", i), obsLog.size(), 1);
            if (obsLog.size() >= 1)
                checkOutput($sformatf("vec%0d_result", i), obsLog[0],
                            {vecs[i].expCout, vecs[i].expOvf, vecs[i].expZero, vecs[i].expF});
        end

        // Back-pressure: four beats offered while out_ready is low for five cycles
        obsLog.delete();
        obsCyc.delete();
        out_ready  = 1'b0;
        acceptBase = acceptCount;
        fork
            begin
                applyStimulus(3'b000, 8'h01, 8'h02, 1'b0, 1'b0);
                applyStimulus(3'b001, 8'h09, 8'h04, 1'b0, 1'b0);
                applyStimulus(3'b110, 8'hF0, 8'h0F, 1'b0, 1'b0);
                applyStimulus(3'b010, 8'h20, 8'h00, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                checkOutput("bp_accepted", acceptCount - acceptBase, 2);
                checkOutput("bp_in_ready", in_ready, 0);
                checkOutput("bp_out_valid", out_valid, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_count", obsLog.size(), 4);
        if (obsLog.size() == 4) begin
            checkOutput("bp_f0", obsLog[0][7:0], 8'h03);
            checkOutput("bp_f1", obsLog[1][7:0], 8'h05);
            checkOutput("bp_f2", obsLog[2][7:0], 8'hFF);
            checkOutput("bp_f3", obsLog[3][7:0], 8'h21);
        end

        // Accumulate chain: four back-to-back beats, three using acc_sel
        obsLog.delete();
        obsCyc.delete();
        if (useAcc) chainExp = '{8'h10, 8'h11, 8'h12, 8'h13};
        else        chainExp = '{8'h10, 8'h21, 8'h21, 8'h21};
        applyStimulus(3'b000, 8'h10, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(3'b000, 8'h20, 8'h01, 1'b0, 1'b1);
        waitDrain();
        checkOutput("chain_count", obsLog.size(), 4);
        if (obsLog.size() == 4) begin
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("chain_f%0d", i), obsLog[i][7:0], chainExp[i]);
            for (int i = 1; i < 4; i++)
                checkOutput($sformatf("chain_cycle%0d", i), obsCyc[i] - obsCyc[0], i);
        end

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        applyStimulus(3'b000, 8'h11, 8'h22, 1'b0, 1'b0);
        applyStimulus(3'b000, 8'h33, 8'h44, 1'b0, 1'b0);
        checkOutput("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_state", {out_valid, in_ready, cout, ovf, zero, f}, {2'b01, 11'h000});
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(3'b000, 8'h03, 8'h04, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("latency_t1", out_valid, 0);
        @(negedge clk);
        checkOutput("latency_t2", {out_valid, f}, {1'b1, 8'h07});
        @(posedge clk);
        #1;
        waitDrain();

        // Randomized stream with random back-pressure and input gaps
        randRun = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
                end
                randRun = 1'b0;
            end
            begin
                while (randRun) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        waitDrain();
        checkOutput("final_queue_empty", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
